sum_accum_unit: RTL and testbench

Parametrised successor to the top-level 8-bit pin adder. It adds operand pairs with selectable wrap or saturating arithmetic, and keeps NUM_CH independent running accumulators. Operations arrive over a valid/ready handshake, and each result is registered with one-cycle latency. The block sits between the tile's input pins/uio bus and uo_out, instantiated inside the tt_um top.

---
 rtl/sum_accum_unit.sv | 121 ++++++++++++
 tb/tb_sum_accum_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum_unit.sv
// sum_accum_unit: wrap/saturating adder with NUM_CH running accumulators.
// Operations enter on a valid/ready handshake; every result lands in a
// single-slot output register one edge after acceptance. Accumulator and
// sticky-flag updates happen in the accept cycle, so back-to-back ACC ops on
// one channel chain without stalling.
module sum_accum_unit #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CHW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [CHW-1:0]    in_ch,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [CHW-1:0]    out_ch,
  output logic              out_ovf,
  output logic [NUM_CH-1:0] ovf_sticky
);

  localparam logic [1:0] MODE_ADDW = 2'b00;
  localparam logic [1:0] MODE_ADDS = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;

  // Clamp a carry-extended sum to all-ones when the carry bit is set.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH:0] s);
    sat_add = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_sum_q, out_sum_d;
  logic [CHW-1:0]    out_ch_q, out_ch_d;
  logic              out_ovf_q, out_ovf_d;
  logic [WIDTH-1:0]  acc_q [NUM_CH];
  logic [WIDTH-1:0]  acc_d [NUM_CH];
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  logic              accept;
  logic [WIDTH:0]    sum_full;
  logic [WIDTH:0]    acc_full;

  // The slot can take a new op when empty or when it is being drained now.
  assign in_ready = ~out_valid_q | out_ready;

  // Next-state: decode the accepted op, update one channel, manage the slot.
  always_comb begin
    accept      = in_valid & in_ready;
    sum_full    = {1'b0, in_a} + {1'b0, in_b};
    acc_full    = {1'b0, acc_q[in_ch]} + {1'b0, in_a};
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ch_d    = out_ch_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (accept) begin
      out_valid_d = 1'b1;
      case (in_mode)
        MODE_ADDW: begin
          out_sum_d = sum_full[WIDTH-1:0];
          out_ovf_d = sum_full[WIDTH];
          out_ch_d  = '0;
        end
        MODE_ADDS: begin
          out_sum_d = sat_add(sum_full);
          out_ovf_d = sum_full[WIDTH];
          out_ch_d  = '0;
        end
        MODE_ACC: begin
          out_sum_d     = acc_full[WIDTH-1:0];
          out_ovf_d     = acc_full[WIDTH];
          out_ch_d      = in_ch;
          acc_d[in_ch]  = acc_full[WIDTH-1:0];
          if (acc_full[WIDTH]) sticky_d[in_ch] = 1'b1;
        end
        default: begin
          // CLR reports the pre-clear value and sticky flag, then zeroes both.
          out_sum_d       = acc_q[in_ch];
          out_ovf_d       = sticky_q[in_ch];
          out_ch_d        = in_ch;
          acc_d[in_ch]    = '0;
          sticky_d[in_ch] = 1'b0;
        end
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset clears the result slot, accumulators and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ch_q    <= out_ch_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_ch     = out_ch_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sum_accum_unit.sv
// Bench for sum_accum_unit: directed scenarios followed by random traffic,
// all compared against a plain-arithmetic reference model.
module tb_sum_accum_unit;
  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int M   = 256;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic [CW-1:0] in_ch, out_ch;
  logic [1:0]    in_mode;
  logic [NCH-1:0] ovf_sticky;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_acc [NCH];
  bit m_sticky [NCH];
  bit e_valid;
  int e_sum;
  bit e_ovf;
  int e_ch;

  sum_accum_unit #(.WIDTH(W), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ch(in_ch), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ch(out_ch), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sticky_vec();
    int v = 0;
    for (int i = 0; i < NCH; i++) if (m_sticky[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i]    = 0;
      m_sticky[i] = 0;
    end
    e_valid = 0; e_sum = 0; e_ovf = 0; e_ch = 0;
  endtask

  // Result of an accepted op, from unsigned integer arithmetic.
  task automatic model_accept(input int mode, input int a, input int b, input int ch);
    int s;
    e_valid = 1;
    case (mode)
      0: begin s = a + b; e_sum = s % M; e_ovf = (s >= M); e_ch = 0; end
      1: begin s = a + b; e_ovf = (s >= M); e_sum = e_ovf ? M - 1 : s; e_ch = 0; end
      2: begin
        s = m_acc[ch] + a;
        e_sum = s % M; e_ovf = (s >= M); e_ch = ch;
        m_acc[ch] = s % M;
        if (s >= M) m_sticky[ch] = 1;
      end
      default: begin
        e_sum = m_acc[ch]; e_ovf = m_sticky[ch]; e_ch = ch;
        m_acc[ch] = 0; m_sticky[ch] = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      check({tag, ".sum"}, 32'(out_sum), 32'(e_sum));
      check({tag, ".ovf"}, 32'(out_ovf), 32'(e_ovf));
      check({tag, ".ch"},  32'(out_ch),  32'(e_ch));
    end
    check({tag, ".sticky"}, 32'(ovf_sticky), 32'(sticky_vec()));
  endtask

  task automatic drive(input int mode, input int a, input int b, input int ch);
    in_valid = 1'b1;
    in_mode  = 2'(mode);
    in_a     = W'(a);
    in_b     = W'(b);
    in_ch    = CW'(ch);
  endtask

  // One accepted op with out_ready high, checked one edge later.
  task automatic op(input int mode, input int a, input int b, input int ch, input string tag);
    out_ready = 1'b1;
    drive(mode, a, b, ch);
    #1;
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    model_accept(mode, a, b, ch);
    step();
    check_out(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    int rm, ra, rb, rc;
    bit exp_rdy;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_ch = '0; in_mode = '0;
    model_reset();
    repeat (2) step();
    check("rst.valid",  32'(out_valid),  32'd0);
    check("rst.sum",    32'(out_sum),    32'd0);
    check("rst.ch",     32'(out_ch),     32'd0);
    check("rst.ovf",    32'(out_ovf),    32'd0);
    check("rst.sticky", 32'(ovf_sticky), 32'd0);
    check("rst.rdy",    32'(in_ready),   32'd1);
    rst = 1'b0;

    // Wrap add, channel input ignored, then drain.
    op(0, 'hF0, 'h20, 3, "addw");
    step();
    e_valid = 0;
    check_out("addw.drain");

    // Saturating add.
    op(1, 'hF0, 'h20, 0, "adds_sat");
    op(1, 'h12, 'h34, 0, "adds");

    // Back-to-back accumulate on channel 2, then read other channels with a=0.
    op(2, 'h80, 0, 2, "acc2_a");
    op(2, 'h80, 0, 2, "acc2_b");
    op(2, 'h80, 0, 2, "acc2_c");
    op(2, 0, 0, 0, "acc0_peek");
    op(2, 0, 0, 1, "acc1_peek");
    op(2, 0, 0, 3, "acc3_peek");

    // Clear channel 2, then accumulate again from zero.
    op(3, 0, 0, 2, "clr2");
    op(2, 'h01, 0, 2, "acc2_after_clr");

    // Backpressure: held result, pending op must not touch channel 0.
    op(2, 'h33, 0, 1, "acc1_33");
    out_ready = 1'b0;
    drive(2, 'h22, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.rdy", 32'(in_ready), 32'd0);
      step();
      check_out("bp.hold");
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_rdy", 32'(in_ready), 32'd1);
    model_accept(2, 'h22, 0, 0);
    step();
    check_out("bp.reload");
    in_valid = 1'b0;

    // Asynchronous reset between edges while a result is pending.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.valid",  32'(out_valid),  32'd0);
    check("arst.sum",    32'(out_sum),    32'd0);
    check("arst.ovf",    32'(out_ovf),    32'd0);
    check("arst.sticky", 32'(ovf_sticky), 32'd0);
    step();
    rst = 1'b0;
    op(2, 1, 0, 1, "acc1_after_rst");

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      rm = int'($urandom_range(0, 3));
      ra = int'($urandom_range(0, M - 1));
      rb = int'($urandom_range(0, M - 1));
      rc = int'($urandom_range(0, NCH - 1));
      drive(rm, ra, rb, rc);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !e_valid || out_ready;
      check("rnd.rdy", 32'(in_ready), 32'(exp_rdy));
      if (in_valid && exp_rdy) model_accept(rm, ra, rb, rc);
      else if (out_ready) e_valid = 0;
      step();
      check_out("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
